// File: rtl/muldiv_sched.sv
// Issue controller and hazard scheduler between EX and the multiply/divide unit.
// Produces a registered one-cycle issue strobe, a combinational stall, and issue/stall statistics.
module muldiv_sched #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ex_valid,
  input  logic [2:0]       ex_op,
  input  logic [31:0]      ex_a,
  input  logic [31:0]      ex_b,
  input  logic             flush,
  output logic             stall,
  output logic [31:0]      md_srca,
  output logic [31:0]      md_srcb,
  output logic [2:0]       md_control,
  output logic             md_used,
  input  logic             md_busy,
  output logic [CNT_W-1:0] issue_count,
  output logic [CNT_W-1:0] stall_count,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic             md_used_q, md_used_d;
  logic [2:0]       md_control_q, md_control_d;
  logic [31:0]      md_srca_q, md_srca_d;
  logic [31:0]      md_srcb_q, md_srcb_d;
  logic [CNT_W-1:0] issue_count_q, issue_count_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic             md_req;
  logic             accept;

  // Handshake: EX offers an op with md_req; it is taken (accept) only in a cycle where
  // stall is low. A stalled op is held in EX by the pipeline and offered again.
  always_comb begin
    md_req = ex_valid & (ex_op != 3'd0) & ~flush;
    stall  = md_req & ((state_q == ISSUE) | md_busy);
    accept = md_req & ~stall & (ex_op != 3'd7);

    state_d       = state_q;
    md_used_d     = accept;
    md_control_d  = accept ? ex_op : 3'd0;
    md_srca_d     = accept ? ex_a : md_srca_q;
    md_srcb_d     = accept ? ex_b : md_srcb_q;
    issue_count_d = accept ? issue_count_q + CNT_ONE : issue_count_q;
    stall_count_d = (stall && (stall_count_q != {CNT_W{1'b1}})) ?
                    stall_count_q + CNT_ONE : stall_count_q;

    // Accept cannot occur in ISSUE, nor in WAIT while the unit is busy, since both stall.
    case (state_q)
      IDLE:    if (accept) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (!md_busy) state_d = accept ? ISSUE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      md_used_q     <= 1'b0;
      md_control_q  <= 3'd0;
      md_srca_q     <= 32'd0;
      md_srcb_q     <= 32'd0;
      issue_count_q <= '0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      md_used_q     <= md_used_d;
      md_control_q  <= md_control_d;
      md_srca_q     <= md_srca_d;
      md_srcb_q     <= md_srcb_d;
      issue_count_q <= issue_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign md_used     = md_used_q;
  assign md_control  = md_control_q;
  assign md_srca     = md_srca_q;
  assign md_srcb     = md_srcb_q;
  assign issue_count = issue_count_q;
  assign stall_count = stall_count_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_muldiv_sched.sv
// Bench for muldiv_sched: directed scenarios plus random traffic, with a cycle-level
// reference model feeding an expected-issue queue that a separate monitor drains.
module tb_muldiv_sched;
  localparam int CW = 4;
  localparam int W  = 67;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          ex_valid = 1'b0;
  logic [2:0]    ex_op = 3'd0;
  logic [31:0]   ex_a = 32'd0;
  logic [31:0]   ex_b = 32'd0;
  logic          flush = 1'b0;
  logic          stall;
  logic [31:0]   md_srca, md_srcb;
  logic [2:0]    md_control;
  logic          md_used;
  logic          md_busy;
  logic [CW-1:0] issue_count, stall_count;
  logic [1:0]    state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] exp_q[$];

  muldiv_sched #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_op(ex_op), .ex_a(ex_a), .ex_b(ex_b),
    .flush(flush), .stall(stall), .md_srca(md_srca), .md_srcb(md_srcb),
    .md_control(md_control), .md_used(md_used), .md_busy(md_busy),
    .issue_count(issue_count), .stall_count(stall_count), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  // Mul/div unit stand-in: busy from the cycle after the issue strobe, 5 cycles for
  // mult/multu, 10 for div/divu, never for mthi/mtlo.
  int busy_cnt = 0;
  always @(posedge clk) begin
    if (reset) busy_cnt <= 0;
    else if (md_used && (md_control == 3'd1 || md_control == 3'd2)) busy_cnt <= 5;
    else if (md_used && (md_control == 3'd3 || md_control == 3'd4)) busy_cnt <= 10;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign md_busy = (busy_cnt != 0);

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // driver tasks: inputs change #1 after the edge, return at the following negedge
  task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic fl, input logic rst);
    @(posedge clk);
    #1;
    ex_valid = v; ex_op = op; ex_a = a; ex_b = b; flush = fl; reset = rst;
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    idle();
    chk("rst_state", state_dbg, 2'd0);
    chk("rst_used", md_used, 1'b0);
    chk("rst_ctrl", md_control, 3'd0);
    chk("rst_srca", md_srca, 32'd0);
    chk("rst_srcb", md_srcb, 32'd0);
    chk("rst_issue_cnt", issue_count, '0);
    chk("rst_stall_cnt", stall_count, '0);
  endtask

  // Hold one op in EX until it is no longer stalled; n = stalled cycles seen.
  task automatic hold_until_go(input logic [2:0] op, input logic [31:0] a,
                               input logic [31:0] b, output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, op, a, b, 1'b0, 1'b0);
      if (!stall) break;
      n++;
    end
  endtask

  // Reference model: the issue slot is the cycle right after an accept; an offered op
  // stalls if it falls on an issue slot or the unit reports busy.
  int           cyc = 0;
  int           last_acc = -100;
  bit           chk_en = 1'b0;
  logic [CW-1:0] m_issue = '0, m_stall = '0;
  logic [31:0]  m_a = 32'd0, m_b = 32'd0;

  always @(negedge clk) begin
    bit req, exp_used, exp_stall, acc;
    req       = ex_valid && (ex_op != 3'd0) && !flush;
    exp_used  = (cyc == last_acc + 1);
    exp_stall = req && (exp_used || md_busy);
    acc       = req && !exp_stall && (ex_op != 3'd7) && !reset;
    if (chk_en) begin
      chk("stall", stall, exp_stall);
      chk("md_used", md_used, exp_used);
      if (!exp_used) chk("md_control_idle", md_control, 3'd0);
      chk("md_srca", md_srca, m_a);
      chk("md_srcb", md_srcb, m_b);
      chk("issue_count", issue_count, m_issue);
      chk("stall_count", stall_count, m_stall);
    end
    if (reset) begin
      chk_en   = 1'b1;
      last_acc = -100;
      m_issue  = '0;
      m_stall  = '0;
      m_a      = 32'd0;
      m_b      = 32'd0;
    end else begin
      if (exp_stall && m_stall != {CW{1'b1}}) m_stall = m_stall + 1'b1;
      if (acc) begin
        m_issue  = m_issue + 1'b1;
        last_acc = cyc;
        m_a      = ex_a;
        m_b      = ex_b;
        exp_q.push_back({ex_op, ex_a, ex_b});
      end
    end
    cyc++;
  end

  // scoreboard monitor: every issue strobe must match the oldest expected issue
  logic prev_used = 1'b0;
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (chk_en) begin
      if (md_used === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL issue_unexpected: got op %0d with no expected issue (t=%0t)",
                   md_control, $time);
        end else begin
          e = exp_q.pop_front();
          chk("issue_payload", {md_control, md_srca, md_srcb}, e);
        end
      end
      chk("md_used_back_to_back", md_used && prev_used, 1'b0);
      prev_used = md_used;
    end
  end

  initial begin
    int n, n2, idle_seen;
    logic r;
    drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b1);

    // mult 3 * -2, then mfhi waits for the result
    do_reset();
    drive(1'b1, 3'd1, 32'd3, 32'hFFFF_FFFE, 1'b0, 1'b0);
    chk("t1_c0_stall", stall, 1'b0);
    drive(1'b1, 3'd7, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("t1_c1_stall", stall, 1'b1);
    chk("t1_c1_used", md_used, 1'b1);
    chk("t1_c1_ctrl", md_control, 3'd1);
    hold_until_go(3'd7, 32'd0, 32'd0, n);
    chk("t1_stalls_c2_c6", n, 5);
    idle();
    chk("t1_stall_count", stall_count, 4'd6);
    chk("t1_issue_count", issue_count, 4'd1);

    // divu then div back-to-back, never returning to IDLE in between
    do_reset();
    drive(1'b1, 3'd4, 32'd100, 32'd7, 1'b0, 1'b0);
    n = 0; idle_seen = 0;
    for (int i = 0; i < 30; i++) begin
      drive(1'b1, 3'd3, 32'hFFFF_FFCE, 32'd5, 1'b0, 1'b0);
      if (state_dbg == 2'd0) idle_seen++;
      if (!stall) break;
      n++;
    end
    chk("t2_stalls", n, 11);
    idle();
    if (state_dbg == 2'd0) idle_seen++;
    chk("t2_used_c13", md_used, 1'b1);
    chk("t2_ctrl_c13", md_control, 3'd3);
    chk("t2_no_idle", idle_seen, 0);

    // mthi then mflo: one stall cycle only
    do_reset();
    drive(1'b1, 3'd5, 32'hDEAD_BEEF, 32'd0, 1'b0, 1'b0);
    drive(1'b1, 3'd7, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("t3_used", md_used, 1'b1);
    chk("t3_ctrl", md_control, 3'd5);
    chk("t3_srca", md_srca, 32'hDEAD_BEEF);
    chk("t3_stall_c1", stall, 1'b1);
    drive(1'b1, 3'd7, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("t3_stall_c2", stall, 1'b0);

    // flush kills a request; flush during a div's busy window leaves it intact
    do_reset();
    drive(1'b1, 3'd1, 32'd1, 32'd1, 1'b1, 1'b0);
    chk("t4_flush_stall", stall, 1'b0);
    idle();
    chk("t4_flush_used", md_used, 1'b0);
    chk("t4_flush_issue", issue_count, 4'd0);
    drive(1'b1, 3'd3, 32'd40, 32'd8, 1'b0, 1'b0);
    n = 0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 3'd1, $urandom, $urandom, 1'b1, 1'b0);
      if (stall) n++;
    end
    chk("t4_flushed_no_stall", n, 0);
    hold_until_go(3'd7, 32'd0, 32'd0, n);
    chk("t4_busy_window_kept", n, 6);

    // reset in the middle of a divide
    do_reset();
    drive(1'b1, 3'd3, 32'd1000, 32'd3, 1'b0, 1'b0);
    idle(); idle(); idle();
    drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    drive(1'b1, 3'd1, 32'd9, 32'd9, 1'b0, 1'b0);
    chk("t5_state", state_dbg, 2'd0);
    chk("t5_used", md_used, 1'b0);
    chk("t5_ctrl", md_control, 3'd0);
    chk("t5_issue_cnt", issue_count, 4'd0);
    chk("t5_stall_cnt", stall_count, 4'd0);
    chk("t5_mult_stall", stall, 1'b0);
    idle();
    chk("t5_mult_used", md_used, 1'b1);
    chk("t5_mult_ctrl", md_control, 3'd1);

    // 17 mtlo accepts wrap a 4-bit issue counter to 1
    do_reset();
    for (int i = 0; i < 33; i++) drive(1'b1, 3'd6, $urandom, $urandom, 1'b0, 1'b0);
    idle();
    chk("t6_issue_wrap", issue_count, 4'd1);

    // 22 stalled cycles saturate a 4-bit stall counter at 15
    do_reset();
    drive(1'b1, 3'd4, 32'd77, 32'd3, 1'b0, 1'b0);
    hold_until_go(3'd3, 32'd5, 32'd2, n);
    hold_until_go(3'd7, 32'd0, 32'd0, n2);
    chk("t6_total_stalls", n + n2, 22);
    idle();
    chk("t6_stall_sat", stall_count, 4'd15);

    // random traffic against the model
    for (int i = 0; i < 600; i++) begin
      r = ($urandom_range(0, 149) == 0);
      drive(r ? 1'b0 : ($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
            $urandom, $urandom, ($urandom_range(0, 9) == 0), r);
    end
    for (int i = 0; i < 15; i++) idle();
    chk("final_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
